// File: rtl/data_mem_unit.sv
// data_mem_unit: memory stage of the single-cycle core. Holds the data RAM,
// a small MMIO block (GPIO, 64-bit cycle counter, sticky fault status and
// fault address), and decodes misaligned and unmapped accesses. Loads are
// combinational; stores and register updates commit on the rising edge.
module data_mem_unit #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  fn3,
  output logic [31:0] mem_out,
  output logic [31:0] gpio_out,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [27:0] OFF_GPIO   = 28'h00;
  localparam logic [27:0] OFF_CYC_LO = 28'h04;
  localparam logic [27:0] OFF_CYC_HI = 28'h08;
  localparam logic [27:0] OFF_STATUS = 28'h0C;
  localparam logic [27:0] OFF_FADDR  = 28'h10;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [31:0] gpio_q, gpio_d;
  logic [63:0] cycle_q, cycle_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic          is_byte, is_half, is_word, is_signed;
  logic          access, misalign, ram_hit, mmio_hit;
  logic          ram_acc, mmio_acc, bus_err;
  logic          ram_we, mmio_we;
  logic [1:0]    fault_set;
  logic [AW-1:0] word_idx;
  logic [27:0]   mmio_off;
  logic [31:0]   ram_word, mmio_rdata, store_data;
  logic [15:0]   ram_half;
  logic [7:0]    ram_byte;
  logic [3:0]    byte_en;

  // Decode access size and signedness; reserved fn3 codes decode to no access.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves a value held (no latch).
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (fn3)
      3'b000:  begin is_byte = 1'b1; is_signed = 1'b1; end
      3'b001:  begin is_half = 1'b1; is_signed = 1'b1; end
      3'b010:  is_word = 1'b1;
      3'b100:  is_byte = 1'b1;
      3'b101:  is_half = 1'b1;
      default: ;
    endcase
  end

  // Region and fault classification. Alignment is checked before the region,
  // so a misaligned access never also reports a bus error.
  assign access    = (mem_read | mem_write) & (is_byte | is_half | is_word);
  assign misalign  = access & ((is_half & alu_out[0]) | (is_word & (alu_out[1:0] != 2'b00)));
  assign ram_hit   = (alu_out[31:AW+2] == '0);
  assign mmio_hit  = (alu_out[31:28] == MMIO_BASE[31:28]) & ~ram_hit;
  assign ram_acc   = access & ~misalign & ram_hit;
  assign mmio_acc  = access & ~misalign & mmio_hit & is_word;
  assign bus_err   = access & ~misalign & ~ram_acc & ~mmio_acc;
  assign fault_set = {bus_err, misalign};

  assign word_idx = alu_out[AW+1:2];
  assign mmio_off = alu_out[27:0];
  assign ram_word = ram_q[word_idx];
  assign ram_byte = ram_word[{alu_out[1:0], 3'b000} +: 8];
  assign ram_half = alu_out[1] ? ram_word[31:16] : ram_word[15:0];

  // MMIO read mux; undefined offsets read as zero.
  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_GPIO:   mmio_rdata = gpio_q;
      OFF_CYC_LO: mmio_rdata = cycle_q[31:0];
      OFF_CYC_HI: mmio_rdata = cycle_q[63:32];
      OFF_STATUS: mmio_rdata = {30'b0, status_q};
      OFF_FADDR:  mmio_rdata = fault_addr_q;
      default:    ;
    endcase
  end

  // Load path: extract and extend the addressed lane; zero for any fault or ignored access.
  always_comb begin
    mem_out = '0;
    if (!reset && mem_read) begin
      if (ram_acc) begin
        if (is_word)      mem_out = ram_word;
        else if (is_half) mem_out = {{16{is_signed & ram_half[15]}}, ram_half};
        else              mem_out = {{24{is_signed & ram_byte[7]}}, ram_byte};
      end else if (mmio_acc) begin
        mem_out = mmio_rdata;
      end
    end
  end

  // Store lane steering: replicate sub-word data across lanes, select with byte enables.
  always_comb begin
    store_data = rs2_data;
    byte_en    = 4'b1111;
    if (is_byte) begin
      store_data = {4{rs2_data[7:0]}};
      byte_en    = 4'b0001 << alu_out[1:0];
    end else if (is_half) begin
      store_data = {2{rs2_data[15:0]}};
      byte_en    = alu_out[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign ram_we  = mem_write & ram_acc & ~reset;
  assign mmio_we = mem_write & mmio_acc;

  // RAM write port with per-byte enables.
  // NOTE: the RAM array is deliberately not reset; only the write is gated by reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram_q[word_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  // Next state of the MMIO registers: GPIO write, W1C then fault set, first-fault address capture.
  always_comb begin
    gpio_d       = gpio_q;
    status_d     = status_q;
    fault_addr_d = fault_addr_q;
    cycle_d      = cycle_q + 64'd1;
    if (mmio_we && mmio_off == OFF_GPIO)   gpio_d   = rs2_data;
    if (mmio_we && mmio_off == OFF_STATUS) status_d = status_q & ~rs2_data[1:0];
    // NOTE: blocking assignments here evaluate in order, so applying the set after the clear makes a same-cycle fault win.
    status_d = status_d | fault_set;
    if (status_q == 2'b00 && fault_set != 2'b00) fault_addr_d = alu_out;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q       <= '0;
      cycle_q      <= '0;
      status_q     <= '0;
      fault_addr_q <= '0;
    end else begin
      gpio_q       <= gpio_d;
      cycle_q      <= cycle_d;
      status_q     <= status_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign gpio_out = gpio_q;
  assign fault    = |status_q;

endmodule
